// File: rtl/chipkill_scrub_ctrl.sv
// Patrol-scrub sequencer for the rank-level (10,8) RS chipkill decoder: walks every line,
// routes each codeword through the external decoder, writes back CEs and keeps chip statistics.
module chipkill_scrub_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_LINES = 65536,
  parameter int unsigned INT_W     = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned FAIL_TH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en,
  input  logic [INT_W-1:0]      interval,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_rsp_valid,
  input  logic [79:0]           rd_rsp_codeword,
  output logic [79:0]           dec_codeword,
  input  logic [1:0]            dec_result,
  input  logic [3:0]            dec_loc,
  input  logic [63:0]           dec_data,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [63:0]           wr_data,
  output logic [10*CNT_W-1:0]   ce_cnt,
  output logic [CNT_W-1:0]      due_cnt,
  output logic [9:0]            chip_fail,
  output logic [ADDR_W-1:0]     last_due_addr,
  output logic                  last_due_valid,
  output logic                  pass_done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE, GAP, RD_REQ, RD_WAIT, DECODE, WR_REQ, NEXT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LINES - 1);

  state_t              state, state_nxt;
  logic [INT_W-1:0]    timer;
  logic [ADDR_W-1:0]   line_addr;
  logic [CNT_W-1:0]    ce_arr [10];
  logic                dec_is_ce;
  logic                dec_is_due;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A CE pointing outside the ten symbols cannot be trusted, so it is treated as a DUE.
  assign dec_is_ce  = (dec_result == 2'b01) && (dec_loc <= 4'd9);
  assign dec_is_due = !dec_is_ce && (dec_result != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scrub_en)     state_nxt = GAP;
      GAP:     if (timer == '0)  state_nxt = RD_REQ;
      RD_REQ:  if (rd_req_ready) state_nxt = RD_WAIT;
      RD_WAIT: if (rd_rsp_valid) state_nxt = DECODE;
      DECODE:  state_nxt = dec_is_ce ? WR_REQ : NEXT;
      WR_REQ:  if (wr_req_ready) state_nxt = NEXT;
      NEXT:    state_nxt = scrub_en ? GAP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_req_valid = (state == RD_REQ);
    wr_req_valid = (state == WR_REQ);
    busy         = (state != IDLE);
    pass_done    = (state == NEXT) && (line_addr == LAST_ADDR);
  end

  assign rd_addr = line_addr;

  // Capture stage: codeword into the decoder, decoder verdict into statistics and writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer          <= '0;
      line_addr      <= '0;
      dec_codeword   <= '0;
      wr_addr        <= '0;
      wr_data        <= '0;
      due_cnt        <= '0;
      last_due_addr  <= '0;
      last_due_valid <= 1'b0;
      for (int i = 0; i < 10; i++) ce_arr[i] <= '0;
    end else begin
      case (state)
        IDLE:    if (scrub_en) timer <= interval;
        GAP:     if (timer != '0) timer <= timer - INT_W'(1);
        RD_WAIT: if (rd_rsp_valid) dec_codeword <= rd_rsp_codeword;
        DECODE: begin
          if (dec_is_ce) begin
            for (int i = 0; i < 10; i++)
              if (dec_loc == 4'(i)) ce_arr[i] <= sat_inc(ce_arr[i]);
            wr_addr <= line_addr;
            wr_data <= dec_data;
          end else if (dec_is_due) begin
            due_cnt        <= sat_inc(due_cnt);
            last_due_addr  <= line_addr;
            last_due_valid <= 1'b1;
          end
        end
        NEXT: begin
          line_addr <= (line_addr == LAST_ADDR) ? '0 : line_addr + ADDR_W'(1);
          if (scrub_en) timer <= interval;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 10; g++) begin : g_chip
    assign ce_cnt[g*CNT_W +: CNT_W] = ce_arr[g];
    assign chip_fail[g]             = 32'(ce_arr[g]) >= FAIL_TH;
  end

endmodule

// File: tb/tb_chipkill_scrub_ctrl.sv
// Directed bench for chipkill_scrub_ctrl: a 4-line rank with a toy decoder whose verdict is
// carried in the low codeword bits; a CNT_W=4 twin shares all inputs for the saturation case.
module tb_chipkill_scrub_ctrl;
  localparam int ADDR_W = 16, NUM_LINES = 4, INT_W = 16, FAIL_TH = 16;
  localparam int CW_A = 5, CW_B = 4;

  logic clk = 1'b0, rst_n = 1'b1, scrub_en = 1'b0;
  logic [INT_W-1:0] interval = '0;
  logic rd_req_ready = 1'b1, rd_rsp_valid = 1'b0, wr_req_ready = 1'b1;
  logic [79:0] rd_rsp_codeword = '0;
  logic [1:0]  dec_result;
  logic [3:0]  dec_loc;
  logic [63:0] dec_data;

  logic rd_req_valid_a, wr_req_valid_a, last_due_valid_a, pass_done_a, busy_a;
  logic [ADDR_W-1:0] rd_addr_a, wr_addr_a, last_due_addr_a;
  logic [79:0] dec_codeword_a;
  logic [63:0] wr_data_a;
  logic [10*CW_A-1:0] ce_cnt_a;
  logic [CW_A-1:0] due_cnt_a;
  logic [9:0] chip_fail_a;

  logic rd_req_valid_b, wr_req_valid_b, last_due_valid_b, pass_done_b, busy_b;
  logic [ADDR_W-1:0] rd_addr_b, wr_addr_b, last_due_addr_b;
  logic [79:0] dec_codeword_b;
  logic [63:0] wr_data_b;
  logic [10*CW_B-1:0] ce_cnt_b;
  logic [CW_B-1:0] due_cnt_b;
  logic [9:0] chip_fail_b;

  chipkill_scrub_ctrl #(.ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES), .INT_W(INT_W),
                        .CNT_W(CW_A), .FAIL_TH(FAIL_TH)) dut_a (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .interval(interval),
    .rd_req_valid(rd_req_valid_a), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr_a),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_codeword(rd_rsp_codeword),
    .dec_codeword(dec_codeword_a), .dec_result(dec_result), .dec_loc(dec_loc),
    .dec_data(dec_data), .wr_req_valid(wr_req_valid_a), .wr_req_ready(wr_req_ready),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .ce_cnt(ce_cnt_a), .due_cnt(due_cnt_a),
    .chip_fail(chip_fail_a), .last_due_addr(last_due_addr_a),
    .last_due_valid(last_due_valid_a), .pass_done(pass_done_a), .busy(busy_a));

  chipkill_scrub_ctrl #(.ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES), .INT_W(INT_W),
                        .CNT_W(CW_B), .FAIL_TH(FAIL_TH)) dut_b (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .interval(interval),
    .rd_req_valid(rd_req_valid_b), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr_b),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_codeword(rd_rsp_codeword),
    .dec_codeword(dec_codeword_b), .dec_result(dec_result), .dec_loc(dec_loc),
    .dec_data(dec_data), .wr_req_valid(wr_req_valid_b), .wr_req_ready(wr_req_ready),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .ce_cnt(ce_cnt_b), .due_cnt(due_cnt_b),
    .chip_fail(chip_fail_b), .last_due_addr(last_due_addr_b),
    .last_due_valid(last_due_valid_b), .pass_done(pass_done_b), .busy(busy_b));

  // Toy decoder: verdict in [1:0], location in [5:2], corrected data in [79:16].
  assign dec_result = dec_codeword_a[1:0];
  assign dec_loc    = dec_codeword_a[5:2];
  assign dec_data   = dec_codeword_a[79:16];

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [79:0] mem [NUM_LINES];
  logic [15:0] rd_log [$];
  int          acc_cyc [$];
  logic [79:0] wr_log [$];
  int cyc = 0, n_pass = 0, pend = 0, rsp_delay = 0;
  logic [79:0] pend_cw = '0;

  function automatic logic [79:0] mk_cw(input logic [1:0] res, input logic [3:0] loc,
                                        input logic [63:0] data);
    return {data, 10'h0, loc, res};
  endfunction

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory model and handshake monitor, all on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_rsp_valid) rd_rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rd_rsp_valid    = 1'b1;
          rd_rsp_codeword = pend_cw;
        end
      end
      if (rst_n && rd_req_valid_a && rd_req_ready) begin
        rd_log.push_back(rd_addr_a);
        acc_cyc.push_back(cyc);
        pend    = 1 + rsp_delay;
        pend_cw = mem[rd_addr_a[1:0]];
      end
      if (rst_n && wr_req_valid_a && wr_req_ready) wr_log.push_back({wr_addr_a, wr_data_a});
      if (pass_done_a) n_pass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy_a && b < 300) begin tick(); b++; end
    if (busy_a) check_val("idle_timeout", busy_a, 1'b0);
  endtask

  // Enables scrubbing until n more reads are accepted, then lets the last line finish.
  task automatic run_lines(input int n);
    int target = rd_log.size() + n;
    int b = 0;
    scrub_en = 1'b1;
    while (rd_log.size() < target && b < 200 * n) begin tick(); b++; end
    scrub_en = 1'b0;
    if (rd_log.size() < target) check_val("run_timeout", rd_log.size(), target);
    wait_idle();
  endtask

  task automatic fill_ne();
    for (int i = 0; i < NUM_LINES; i++) mem[i] = mk_cw(2'b00, 4'd0, 64'h1111_0000 + 64'(i));
  endtask

  localparam logic [63:0] D_CE  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D_BP  = 64'h0123_4567_89AB_CDEF;

  initial begin : stim
    int b;
    int n_rd0, n_wr0;
    logic stable;
    fill_ne();
    #2 rst_n = 1'b0;
    tick(); tick();
    check_val("rst_ctrl", {busy_a, rd_req_valid_a, wr_req_valid_a, pass_done_a,
                           last_due_valid_a}, 5'b0);
    check_val("rst_stats", {ce_cnt_a, due_cnt_a, chip_fail_a}, '0);
    check_val("rst_codeword", dec_codeword_a, '0);
    rst_n = 1'b1;
    tick();

    // Clean pass: 0,1,2,3 then wrap to 0.
    run_lines(5);
    check_val("pass_order", {rd_log[0], rd_log[1], rd_log[2], rd_log[3], rd_log[4]},
              {16'd0, 16'd1, 16'd2, 16'd3, 16'd0});
    check_val("best_case_line", acc_cyc[1] - acc_cyc[0], 5);
    check_val("pass_done_once", n_pass, 1);
    check_val("clean_no_write", wr_log.size(), 0);

    // Single-chip CE on line 2 (lines 1,2 processed).
    mem[2] = mk_cw(2'b01, 4'd3, D_CE);
    run_lines(2);
    check_val("ce_lines", {rd_log[5], rd_log[6]}, {16'd1, 16'd2});
    check_val("ce_cnt_a", ce_cnt_a, 50'd1 << 15);
    check_val("ce_cnt_b", ce_cnt_b, 40'd1 << 12);
    check_val("ce_wr_count", wr_log.size(), 1);
    check_val("ce_wr", wr_log[0], {16'd2, D_CE});
    check_val("ce_codeword", dec_codeword_a, mk_cw(2'b01, 4'd3, D_CE));
    check_val("ce_no_due", {due_cnt_a, last_due_valid_a}, '0);

    // DUE variants: line 3 CE at loc 12, line 0 result 11, line 1 result 10.
    fill_ne();
    mem[3] = mk_cw(2'b01, 4'd12, 64'h3);
    mem[0] = mk_cw(2'b11, 4'd0, 64'h0);
    mem[1] = mk_cw(2'b10, 4'd0, 64'h1);
    run_lines(3);
    check_val("due_cnt", due_cnt_a, 5'd3);
    check_val("due_last", {last_due_valid_a, last_due_addr_a}, {1'b1, 16'd1});
    check_val("due_no_write", wr_log.size(), 1);
    check_val("due_ce_unchanged", ce_cnt_a, 50'd1 << 15);
    check_val("pass_done_twice", n_pass, 2);

    // Backpressure on line 2 (CE at loc 5), scrub_en dropped during the writeback.
    fill_ne();
    mem[2] = mk_cw(2'b01, 4'd5, D_BP);
    n_rd0 = rd_log.size();
    n_wr0 = wr_log.size();
    rd_req_ready = 1'b0;
    wr_req_ready = 1'b0;
    scrub_en = 1'b1;
    b = 0;
    while (!rd_req_valid_a && b < 50) begin tick(); b++; end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(rd_req_valid_a && rd_addr_a == 16'd2)) stable = 1'b0;
      tick();
    end
    check_val("rd_hold", {stable, rd_req_valid_a, rd_addr_a}, {1'b1, 1'b1, 16'd2});
    rd_req_ready = 1'b1;
    b = 0;
    while (!wr_req_valid_a && b < 50) begin tick(); b++; end
    scrub_en = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(wr_req_valid_a && wr_addr_a == 16'd2 && wr_data_a == D_BP)) stable = 1'b0;
      tick();
    end
    check_val("wr_hold", {stable, wr_req_valid_a, wr_addr_a}, {1'b1, 1'b1, 16'd2});
    wr_req_ready = 1'b1;
    wait_idle();
    check_val("bp_accepts", {8'(rd_log.size() - n_rd0), 8'(wr_log.size() - n_wr0)},
              {8'd1, 8'd1});
    check_val("bp_wr", wr_log[wr_log.size() - 1], {16'd2, D_BP});
    check_val("bp_ce_cnt", ce_cnt_a, (50'd1 << 15) | (50'd1 << 25));
    run_lines(1);
    check_val("resume_addr", rd_log[rd_log.size() - 1], 16'd3);

    // Threshold and saturation on chip 9.
    for (int i = 0; i < NUM_LINES; i++) mem[i] = mk_cw(2'b01, 4'd9, 64'h9900 + 64'(i));
    for (int k = 1; k <= 20; k++) begin
      run_lines(1);
      if (k == 15) begin
        check_val("ce15_a", {ce_cnt_a[45 +: 5], chip_fail_a}, {5'd15, 10'h000});
        check_val("ce15_b", ce_cnt_b[36 +: 4], 4'd15);
      end
      if (k == 16) check_val("ce16_a", {ce_cnt_a[45 +: 5], chip_fail_a}, {5'd16, 10'h200});
      if (k == 20) begin
        check_val("ce20_a", {ce_cnt_a[45 +: 5], chip_fail_a}, {5'd20, 10'h200});
        check_val("ce20_b_sat", {ce_cnt_b[36 +: 4], chip_fail_b}, {4'd15, 10'h000});
      end
    end

    // Reset during RD_WAIT with the response still outstanding.
    fill_ne();
    rsp_delay = 5;
    n_rd0 = rd_log.size();
    scrub_en = 1'b1;
    b = 0;
    while (rd_log.size() == n_rd0 && b < 50) begin tick(); b++; end
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_ctrl", {busy_a, rd_req_valid_a, wr_req_valid_a, pass_done_a,
                               last_due_valid_a, chip_fail_a, due_cnt_a}, '0);
    check_val("mid_rst_cnt", ce_cnt_a, '0);
    check_val("mid_rst_addr", {rd_addr_a, wr_addr_a, last_due_addr_a}, '0);
    check_val("mid_rst_data", {dec_codeword_a[15:0], wr_data_a}, '0);
    scrub_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check_val("stray_rsp_ignored", {busy_a, dec_codeword_a}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
